// File: rtl/vc_rr_buffer.sv
// Virtual-channel buffer: one push stream is sorted into NUM_VC FIFOs by its top bits
// and drained round-robin onto a single registered, stall-aware output.
module vc_rr_buffer #(
  parameter int DATA_W = 6,
  parameter int NUM_VC = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         init,
  input  logic [$clog2(DEPTH):0]       af_thr_i,
  input  logic [$clog2(DEPTH):0]       ae_thr_i,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         push,
  input  logic                         stall_in,
  output logic                         pause_out,
  output logic [NUM_VC-1:0]            empty_o,
  output logic [NUM_VC-1:0]            almost_empty_o,
  output logic [DATA_W-1:0]            data_out,
  output logic                         valid_out,
  output logic [NUM_VC-1:0]            error_out,
  output logic                         idle_out,
  output logic                         active_out,
  output logic [2:0]                   state_o
);

  localparam int SEL_W = $clog2(NUM_VC);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]    wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]    rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]    rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]    cnt_q    [NUM_VC];
  logic [CNT_W-1:0]    cnt_d    [NUM_VC];
  logic [CNT_W-1:0]    af_thr_q, af_thr_d;
  logic [CNT_W-1:0]    ae_thr_q, ae_thr_d;
  logic [CNT_W-1:0]    af_in_s, ae_in_s;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [NUM_VC-1:0]   err_q, err_d;

  logic [SEL_W-1:0]    push_vc_s;
  logic [SEL_W-1:0]    grant_s;
  logic [NUM_VC-1:0]   nonempty_s;
  logic                any_s, run_s, push_full_s, push_ok_s, ovf_s, pop_s;

  // Classification, push/pop qualification and threshold clamping
  always_comb begin
    push_vc_s = data_in[DATA_W-1 -: SEL_W];
    run_s     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    for (int v = 0; v < NUM_VC; v++) begin
      nonempty_s[v] = (cnt_q[v] != {CNT_W{1'b0}});
    end
    any_s       = |nonempty_s;
    push_full_s = (cnt_q[push_vc_s] == CNT_W'(DEPTH));
    push_ok_s   = run_s && push && !push_full_s;
    ovf_s       = run_s && push && push_full_s;
    pop_s       = run_s && !stall_in && any_s;
    if ((af_thr_i == {CNT_W{1'b0}}) || (af_thr_i > CNT_W'(DEPTH))) begin
      af_in_s = CNT_W'(DEPTH);
    end else begin
      af_in_s = af_thr_i;
    end
    if (ae_thr_i >= af_in_s) begin
      ae_in_s = af_in_s - CNT_W'(1);
    end else begin
      ae_in_s = ae_thr_i;
    end
  end

  // Round-robin search starting one past the last granted VC
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    grant_s = rr_ptr_q;
    found   = 1'b0;
    idx     = rr_ptr_q;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = rr_ptr_q + SEL_W'(i);
      if (!found && nonempty_s[idx]) begin
        grant_s = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Next-state for FIFO bookkeeping, output register, errors and thresholds
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      logic inc, dec;
      inc = push_ok_s && (push_vc_s == SEL_W'(v));
      dec = pop_s && (grant_s == SEL_W'(v));
      if (state_q == ST_INIT) begin
        wr_ptr_d[v] = {PTR_W{1'b0}};
        rd_ptr_d[v] = {PTR_W{1'b0}};
        cnt_d[v]    = {CNT_W{1'b0}};
      end else begin
        wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(inc);
        rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(dec);
        cnt_d[v]    = cnt_q[v] + CNT_W'(inc) - CNT_W'(dec);
      end
    end
    rr_ptr_d = pop_s ? grant_s : rr_ptr_q;
    valid_d  = pop_s;
    data_d   = pop_s ? mem_q[grant_s][rd_ptr_q[grant_s]] : data_q;
    err_d    = err_q;
    if (state_q == ST_INIT) begin
      err_d    = {NUM_VC{1'b0}};
      af_thr_d = af_in_s;
      ae_thr_d = ae_in_s;
    end else begin
      af_thr_d = af_thr_q;
      ae_thr_d = ae_thr_q;
      if (ovf_s) begin
        err_d[push_vc_s] = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // Control FSM transitions; init outranks overflow
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (init)                state_d = ST_INIT;
        else if (ovf_s)          state_d = ST_ERROR;
        else if (push || any_s)  state_d = ST_ACTIVE;
        else                     state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (init)                state_d = ST_INIT;
        else if (ovf_s)          state_d = ST_ERROR;
        else if (!push && !any_s) state_d = ST_IDLE;
        else                     state_d = ST_ACTIVE;
      end
      ST_ERROR: state_d = init ? ST_INIT : ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  // Control and bookkeeping registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= {PTR_W{1'b0}};
        rd_ptr_q[v] <= {PTR_W{1'b0}};
        cnt_q[v]    <= {CNT_W{1'b0}};
      end
      af_thr_q <= CNT_W'(DEPTH - 1);
      ae_thr_q <= CNT_W'(1);
      rr_ptr_q <= {SEL_W{1'b0}};
      data_q   <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
      err_q    <= {NUM_VC{1'b0}};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      af_thr_q <= af_thr_d;
      ae_thr_q <= ae_thr_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents are only meaningful where the count says so
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[push_vc_s][wr_ptr_q[push_vc_s]] <= data_in;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Status flags straight from registered counts and latched thresholds
  always_comb begin
    pause_out = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      empty_o[v]        = (cnt_q[v] == {CNT_W{1'b0}});
      almost_empty_o[v] = (cnt_q[v] <= ae_thr_q);
      pause_out         = pause_out | (cnt_q[v] >= af_thr_q);
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign error_out  = err_q;
  assign state_o    = state_q;
  assign idle_out   = (state_q == ST_IDLE);
  assign active_out = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_vc_rr_buffer.sv
// Directed bench for vc_rr_buffer: init, pass-through, stall, round-robin order,
// overflow/error recovery, threshold clamping and asynchronous reset.
module tb_vc_rr_buffer;

  logic       clk = 1'b0;
  logic       reset_L, init, push, stall_in;
  logic [2:0] af_thr_i, ae_thr_i;
  logic [5:0] data_in;
  logic       pause_out, valid_out, idle_out, active_out;
  logic [3:0] empty_o, almost_empty_o, error_out;
  logic [5:0] data_out;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  vc_rr_buffer #(.DATA_W(6), .NUM_VC(4), .DEPTH(4)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .af_thr_i(af_thr_i), .ae_thr_i(ae_thr_i),
    .data_in(data_in), .push(push), .stall_in(stall_in), .pause_out(pause_out),
    .empty_o(empty_o), .almost_empty_o(almost_empty_o), .data_out(data_out),
    .valid_out(valid_out), .error_out(error_out), .idle_out(idle_out),
    .active_out(active_out), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [5:0] w);
    data_in = w;
    push    = 1'b1;
    step();
    push    = 1'b0;
  endtask

  initial begin
    reset_L = 1'b0; init = 1'b0; push = 1'b0; stall_in = 1'b0;
    af_thr_i = 3'd0; ae_thr_i = 3'd0; data_in = 6'h00;
    #12;
    check("rst_state", state_o, 3'd0);
    check("rst_empty", empty_o, 4'b1111);
    check("rst_ae", almost_empty_o, 4'b1111);
    check("rst_pause", pause_out, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, 6'h00);
    check("rst_idle", idle_out, 1'b0);

    reset_L = 1'b1; init = 1'b1; af_thr_i = 3'd3; ae_thr_i = 3'd1;
    step();
    check("init_state", state_o, 3'd1);
    step();
    init = 1'b0;
    step();
    check("idle_state", state_o, 3'd2);
    check("idle_out", idle_out, 1'b1);
    check("idle_empty", empty_o, 4'b1111);
    check("idle_err", error_out, 4'b0000);

    // Pass-through, one cycle after each push
    push_word(6'h05);
    check("act_out", active_out, 1'b1);
    check("p0_valid_early", valid_out, 1'b0);
    step();
    check("p0_valid", valid_out, 1'b1);
    check("p0_data", data_out, 6'h05);
    push_word(6'h12);
    check("p1_valid_early", valid_out, 1'b0);
    step();
    check("p1_valid", valid_out, 1'b1);
    check("p1_data", data_out, 6'h12);
    step();
    check("p1_hold_valid", valid_out, 1'b0);
    check("p1_hold_data", data_out, 6'h12);
    check("back_idle", state_o, 3'd2);

    // Stalled fill of VC2, then drain in order
    stall_in = 1'b1;
    push_word(6'h21);
    push_word(6'h22);
    check("vc2_pause_lo", pause_out, 1'b0);
    push_word(6'h23);
    check("vc2_pause_hi", pause_out, 1'b1);
    check("vc2_ae", almost_empty_o, 4'b1011);
    check("vc2_empty", empty_o, 4'b1011);
    check("vc2_stalled", valid_out, 1'b0);
    stall_in = 1'b0;
    step();
    check("vc2_d0", data_out, 6'h21);
    check("vc2_pause_drop", pause_out, 1'b0);
    step();
    check("vc2_d1", data_out, 6'h22);
    step();
    check("vc2_d2", data_out, 6'h23);
    check("vc2_v2", valid_out, 1'b1);
    step();
    check("vc2_done", valid_out, 1'b0);

    // Bring rr pointer back to VC0
    push_word(6'h06);
    step();
    check("vc0_d", data_out, 6'h06);
    step();

    // Round-robin order with rr pointer at VC0
    stall_in = 1'b1;
    push_word(6'h01);
    push_word(6'h11);
    push_word(6'h21);
    push_word(6'h31);
    check("rr_empty", empty_o, 4'b0000);
    stall_in = 1'b0;
    step();
    check("rr_g0", data_out, 6'h11);
    step();
    check("rr_g1", data_out, 6'h21);
    step();
    check("rr_g2", data_out, 6'h31);
    step();
    check("rr_g3", data_out, 6'h01);
    step();
    check("rr_end", valid_out, 1'b0);

    // Overflow of VC3
    stall_in = 1'b1;
    push_word(6'h31);
    push_word(6'h32);
    push_word(6'h33);
    push_word(6'h34);
    check("ovf_pre_err", error_out, 4'b0000);
    check("ovf_pre_state", state_o, 3'd3);
    push_word(6'h35);
    check("ovf_err", error_out, 4'b1000);
    check("ovf_state", state_o, 3'd4);
    stall_in = 1'b0;
    step();
    check("err_no_pop", valid_out, 1'b0);
    push_word(6'h05);
    check("err_no_push", empty_o, 4'b0111);
    check("err_hold", state_o, 3'd4);

    // Re-init with out-of-range thresholds: af 0 -> 4, ae 5 -> 3
    init = 1'b1; af_thr_i = 3'd0; ae_thr_i = 3'd5;
    step();
    check("reinit_state", state_o, 3'd1);
    step();
    check("reinit_err", error_out, 4'b0000);
    check("reinit_flush", empty_o, 4'b1111);
    init = 1'b0;
    step();
    check("reinit_idle", state_o, 3'd2);

    stall_in = 1'b1;
    push_word(6'h01);
    push_word(6'h02);
    push_word(6'h03);
    check("clamp_pause_lo", pause_out, 1'b0);
    check("clamp_ae_hi", almost_empty_o, 4'b1111);
    push_word(6'h04);
    check("clamp_pause_hi", pause_out, 1'b1);
    check("clamp_ae_lo", almost_empty_o, 4'b1110);
    stall_in = 1'b0;
    step();
    check("burst_d0", data_out, 6'h01);
    check("burst_v0", valid_out, 1'b1);

    // Asynchronous reset mid-burst, checked before the next edge
    #2;
    reset_L = 1'b0;
    #1;
    check("arst_state", state_o, 3'd0);
    check("arst_valid", valid_out, 1'b0);
    check("arst_data", data_out, 6'h00);
    check("arst_empty", empty_o, 4'b1111);
    check("arst_ae", almost_empty_o, 4'b1111);
    check("arst_pause", pause_out, 1'b0);
    check("arst_err", error_out, 4'b0000);
    check("arst_act", active_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_rr_buffer.md
Name: vc_rr_buffer

Overview:
Parametrised successor to the fixed two-destination conditioning path. It takes a single push stream and classifies each word into one of NUM_VC virtual-channel FIFOs using the word's top bits. It drains the VCs through a round-robin arbiter onto one registered output that honours downstream stall. It carries the init/idle/active/error control FSM, programmable almost-full/almost-empty thresholds, upstream pause and per-VC sticky overflow errors.

Parameters:
DATA_W, 6, word width; must be > SEL_W.
NUM_VC, 4, number of virtual channels; power of 2, >= 2.
DEPTH, 4, entries per VC FIFO; power of 2, >= 2.
(localparams) SEL_W = clog2(NUM_VC); CNT_W = clog2(DEPTH)+1.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset_L  in  1  asynchronous, active-low reset.
init  in  1  request entry to / hold in INIT and latch thresholds.
af_thr_i  in  CNT_W  almost-full threshold; latched in INIT.
ae_thr_i  in  CNT_W  almost-empty threshold; latched in INIT.
data_in  in  DATA_W  push word; VC = data_in[DATA_W-1 -: SEL_W].
push  in  1  push strobe.
stall_in  in  1  downstream backpressure; 1 = no pop this cycle.
pause_out  out  1  any VC count >= latched af threshold.
empty_o  out  NUM_VC  bit i = VC i count == 0.
almost_empty_o  out  NUM_VC  bit i = VC i count <= latched ae threshold.
data_out  out  DATA_W  registered popped word.
valid_out  out  1  data_out carries a new word this cycle.
error_out  out  NUM_VC  sticky overflow flag per VC.
idle_out  out  1  state == IDLE.
active_out  out  1  state == ACTIVE.
state_o  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.

Behaviour:
- Reset (async, reset_L=0) values: state RESET; all counts, pointers and rr pointer 0; data_out 0; valid_out 0; error_out 0; af threshold DEPTH-1; ae threshold 1. Outputs during reset: pause_out 0, empty_o all 1, almost_empty_o all 1, idle_out 0, active_out 0. Reset mid-operation discards all contents.
- FSM:
  - RESET: goes to INIT on the first edge with reset_L=1.
  - INIT: latch thresholds every cycle; flush all VCs; clear error_out; go to IDLE on the edge where init=0.
  - IDLE: go to ACTIVE if push=1 or any VC is non-empty.
  - ACTIVE: go to IDLE when all VCs are empty and push=0.
  - From IDLE, ACTIVE or ERROR: init=1 takes priority and goes to INIT.
  - From IDLE or ACTIVE: an overflow goes to ERROR.
  - ERROR: holds until init or reset.
- Threshold clamping at latch:
  - af of 0 or > DEPTH is stored as DEPTH.
  - ae >= stored af is stored as af-1.
- Push:
  - Accepted only in IDLE or ACTIVE; ignored in RESET, INIT and ERROR.
  - If the target VC count == DEPTH, this is an overflow: the word is dropped and error_out[vc] is set. This applies even if the same VC pops in the same cycle.
- Pop:
  - Allowed only in IDLE or ACTIVE, when stall_in=0 and at least one VC is non-empty, decided on registered counts.
  - The arbiter grants the first non-empty VC starting at rr_ptr+1 modulo NUM_VC; rr_ptr then becomes the granted VC.
  - data_out and valid_out update on the same edge. data_out holds its last value while valid_out=0.
  - In ERROR, popping stops and valid_out=0.
- Latency: a word pushed at edge k into an empty VC is eligible for pop at edge k+1, giving valid_out=1 after edge k+1. A same-cycle push and pop on an empty VC does not forward the new word.
- Simultaneous push and pop on one VC that is not full: the count is unchanged and the FIFO order is preserved.
- Pointers wrap modulo DEPTH. The count is CNT_W wide and never exceeds DEPTH.
- pause_out, empty_o and almost_empty_o are combinational from registered counts and latched thresholds.

Test Plan:
- Reset, then init=1 with af=3, ae=1, then init=0 -> state_o 0→1→2; idle_out=1; empty_o=4'b1111; error_out=0.
- Push 6'h05 (VC0), then 6'h12 (VC1) with stall_in=0 -> valid_out pulses with data_out 6'h05 then 6'h12, each one cycle after its push; state returns to IDLE.
- With stall_in=1, push 3 words to VC2 (6'h21, 6'h22, 6'h23) -> pause_out=1 after the third push; almost_empty_o[2]=0. Release stall -> output in push order, pause_out drops after the first pop.
- With stall_in=1, push 1 word each to VC0..VC3, then release -> grant order VC1, VC2, VC3, VC0 (rr_ptr starts at 0).
- With stall_in=1, push 5 words to VC3 -> fifth word dropped; error_out=4'b1000; state ERROR; valid_out stays 0. Then init=1 -> INIT, error_out=0, VC3 flushed.
- Drop reset_L mid-burst -> all outputs take their reset values asynchronously, before the next clk edge.
